intra_pass_scheduler: RTL and testbench
=======================================

Name: intra_pass_scheduler

Overview:
- Sequences one frame through the intra prediction / transform / reconstruction loop.
- Replaces the free-running rotating enable with a handshaked pass scheduler: one pass of the 9 pipeline enables per 4x4 luma block, with one 8x8 chroma block (Cb and Cr together) on every 4th pass.
- Drives the block-number inputs of the predictor and reconstructor, and waits for reconstructor feedback before starting the next pass.
- Flags a frame-done pulse, or a sticky error if feedback times out.

Parameters:
- WIDTH, 1280, luma frame width in pixels; multiple of 8.
- LENGTH, 720, luma frame height in pixels; multiple of 8.
- NSTAGE, 9, number of one-hot pipeline enables per pass.
- FB_TIMEOUT, 15, maximum cycles allowed in WAIT_FB before error.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle pulse that begins a frame; ignored unless in IDLE.
- pause  in  1  freezes the scheduler while high.
- fb_luma4x4  in  1  reconstructor reports the luma block is written back.
- fb_chromab8x8  in  1  reconstructor reports the Cb block is written back.
- fb_chromar8x8  in  1  reconstructor reports the Cr block is written back.
- enabler  out  NSTAGE  one-hot stage enable; bit k enables pipeline stage k.
- chroma_en  out  1  high for the whole pass when this pass carries a chroma block.
- mbnumber_luma4x4  out  32  raster index of the current 4x4 luma block.
- mbnumber_chromab8x8  out  32  raster index of the current 8x8 Cb block.
- mbnumber_chromar8x8  out  32  raster index of the current 8x8 Cr block; always equal to the Cb index.
- busy  out  1  high in RUN and WAIT_FB.
- frame_done  out  1  one-cycle pulse at frame completion.
- error  out  1  sticky feedback-timeout flag.

Behaviour:
- Constants: NL = (WIDTH/4)*(LENGTH/4); NC = NL/4.
- Reset values: enabler=0, chroma_en=0, all mbnumbers=0, busy=0, frame_done=0, error=0, state=IDLE, internal flags and counters=0.
- States: IDLE, RUN, WAIT_FB, DONE, ERR.
- IDLE:
  - enabler=0.
  - On start: go to RUN with enabler=1 (bit 0) on the next cycle.
  - Load chroma_en=1 (luma index 0 satisfies index mod 4 = 0).
  - Clear the sticky fb flags.
- RUN:
  - enabler shifts left one position per cycle: bit 0 through bit NSTAGE-1, exactly one cycle each.
  - The cycle after bit NSTAGE-1 is active: enabler=0, state=WAIT_FB, timeout counter=0.
- Sticky fb flags:
  - fl, fb, fr capture their fb_* inputs (OR) during every RUN and WAIT_FB cycle.
  - Feedback arriving during the last enable stage is therefore not lost.
- WAIT_FB:
  - Done condition: fl & (~chroma_en | (fb & fr)), evaluated on the registered flags plus the current inputs.
  - On done, last pass (luma index = NL-1): go to DONE.
  - On done, otherwise:
    - Increment the luma index.
    - Increment the chroma index if the new luma index mod 4 = 0.
    - Set chroma_en = (new luma index mod 4 = 0).
    - Clear the flags.
    - Re-enter RUN with enabler=1 on the next cycle.
  - Minimum pass length is NSTAGE+1 cycles.
  - Otherwise the timeout counter increments. When it reaches FB_TIMEOUT without done: go to ERR, error=1.
- DONE:
  - frame_done=1 for exactly one cycle; busy=0.
  - Then IDLE.
  - mbnumbers reset to 0 on the IDLE entry.
- ERR:
  - enabler=0, busy=0; error stays high until reset.
  - start is ignored.
  - mbnumbers hold the failing block's indices for debug.
- pause:
  - While high in RUN or WAIT_FB, all state, flags, counters and mbnumbers hold and enabler=0.
  - On release, the same stage bit is re-asserted; the stage is not skipped or repeated beyond the pause.
  - fb inputs are still captured into the flags during pause.
  - pause in IDLE, DONE or ERR has no effect.
- start while busy is ignored. start and reset together: reset wins.
- Reset mid-frame returns to the reset values on the next edge; the in-flight pass is abandoned.
- Chroma index wraps never: it reaches NC-1 on luma index NL-4 and holds.
- mbnumber outputs are registered and change only at a pass boundary, never mid-pass.

Test Plan:
- WIDTH=16, LENGTH=8 (NL=8, NC=2), fb_* tied high, start pulse →
  - 8 passes of 10 cycles each.
  - luma index 0..7; chroma index 0,0,0,0,1,1,1,1.
  - chroma_en high on passes 0 and 4 only.
  - frame_done pulses once, 80 cycles after start+1.
- fb_luma4x4 pulses during the stage-8 cycle only, chroma fb never, on pass 1 (chroma_en=0) → the pulse is captured and the pass completes with 1 WAIT_FB cycle.
- Pass 0, fb_luma4x4 only, chroma fb withheld 15 cycles → error=1, busy=0, enabler=0, mbnumber_luma4x4 = 0; a later start is ignored.
- pause held 5 cycles while enabler=9'b000001000 → enabler=0 for 5 cycles, then 9'b000001000 again, then normal shifting; the pass takes 15 cycles.
- reset asserted during pass 3 of 8 → next cycle all outputs are 0 and the state is IDLE; a new start restarts at luma index 0.
- start re-pulsed during RUN, together with the frame_done cycle → no effect on counters or the enable sequence.

Source files
------------

// File: rtl/intra_pass_scheduler.sv
// Handshaked pass scheduler for the intra prediction / transform / reconstruction loop.
// One pass of NSTAGE one-hot enables per 4x4 luma block; every 4th pass also carries an 8x8 chroma pair.
module intra_pass_scheduler #(
    parameter int WIDTH      = 1280,
    parameter int LENGTH     = 720,
    parameter int NSTAGE     = 9,
    parameter int FB_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pause,
    input  logic              fb_luma4x4,
    input  logic              fb_chromab8x8,
    input  logic              fb_chromar8x8,
    output logic [NSTAGE-1:0] enabler,
    output logic              chroma_en,
    output logic [31:0]       mbnumber_luma4x4,
    output logic [31:0]       mbnumber_chromab8x8,
    output logic [31:0]       mbnumber_chromar8x8,
    output logic              busy,
    output logic              frame_done,
    output logic              error
);

    localparam int NL = (WIDTH / 4) * (LENGTH / 4);
    localparam logic [31:0] LAST_LUMA = 32'(NL - 1);
    localparam int TW = $clog2(FB_TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(FB_TIMEOUT - 1);
    localparam logic [NSTAGE-1:0] STAGE0 = {{(NSTAGE-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        WAIT_FB,
        DONE,
        ERR
    } state_t;

    state_t            state_q, state_d;
    logic [NSTAGE-1:0] stage_q, stage_d;
    logic              chroma_q, chroma_d;
    logic [31:0]       luma_q, luma_d;
    logic [31:0]       cidx_q, cidx_d;
    logic              fl_q, fl_d;
    logic              fcb_q, fcb_d;
    logic              fcr_q, fcr_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic              err_q, err_d;

    logic              active;
    logic              fl_now, fcb_now, fcr_now;
    logic              pass_done;
    logic [31:0]       luma_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            stage_q  <= '0;
            chroma_q <= 1'b0;
            luma_q   <= '0;
            cidx_q   <= '0;
            fl_q     <= 1'b0;
            fcb_q    <= 1'b0;
            fcr_q    <= 1'b0;
            tcnt_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            chroma_q <= chroma_d;
            luma_q   <= luma_d;
            cidx_q   <= cidx_d;
            fl_q     <= fl_d;
            fcb_q    <= fcb_d;
            fcr_q    <= fcr_d;
            tcnt_q   <= tcnt_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        chroma_d = chroma_q;
        luma_d   = luma_q;
        cidx_d   = cidx_q;
        fl_d     = fl_q;
        fcb_d    = fcb_q;
        fcr_d    = fcr_q;
        tcnt_d   = tcnt_q;
        err_d    = err_q;

        active    = (state_q == RUN) || (state_q == WAIT_FB);
        fl_now    = fl_q | fb_luma4x4;
        fcb_now   = fcb_q | fb_chromab8x8;
        fcr_now   = fcr_q | fb_chromar8x8;
        pass_done = fl_now & (~chroma_q | (fcb_now & fcr_now));
        luma_inc  = luma_q + 32'd1;

        // Feedback is latched even while paused so a pulse during a freeze is not lost.
        if (active) begin
            fl_d  = fl_now;
            fcb_d = fcb_now;
            fcr_d = fcr_now;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    stage_d  = STAGE0;
                    chroma_d = 1'b1;
                    luma_d   = '0;
                    cidx_d   = '0;
                    fl_d     = 1'b0;
                    fcb_d    = 1'b0;
                    fcr_d    = 1'b0;
                end
            end
            RUN: begin
                if (!pause) begin
                    if (stage_q[NSTAGE-1]) begin
                        state_d = WAIT_FB;
                        stage_d = '0;
                        tcnt_d  = '0;
                    end else begin
                        stage_d = stage_q << 1;
                    end
                end
            end
            WAIT_FB: begin
                if (!pause) begin
                    if (pass_done) begin
                        if (luma_q == LAST_LUMA) begin
                            state_d = DONE;
                        end else begin
                            state_d  = RUN;
                            stage_d  = STAGE0;
                            luma_d   = luma_inc;
                            chroma_d = (luma_inc[1:0] == 2'b00);
                            if (luma_inc[1:0] == 2'b00) begin
                                cidx_d = cidx_q + 32'd1;
                            end
                            fl_d  = 1'b0;
                            fcb_d = 1'b0;
                            fcr_d = 1'b0;
                        end
                    end else if (tcnt_q == T_LAST) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end
            DONE: begin
                state_d  = IDLE;
                luma_d   = '0;
                cidx_d   = '0;
                chroma_d = 1'b0;
            end
            ERR: begin
                // Indices are held for debug; only reset leaves this state.
                state_d = ERR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign enabler             = ((state_q == RUN) && !pause) ? stage_q : '0;
    assign chroma_en           = chroma_q;
    assign mbnumber_luma4x4    = luma_q;
    assign mbnumber_chromab8x8 = cidx_q;
    assign mbnumber_chromar8x8 = cidx_q;
    assign busy                = active;
    assign frame_done          = (state_q == DONE);
    assign error               = err_q;

endmodule

// File: tb/tb_intra_pass_scheduler.sv
// Directed self-checking bench for intra_pass_scheduler on a 16x8 frame (8 luma passes, 2 chroma blocks).
module tb_intra_pass_scheduler;

    localparam int NST = 9;

    logic           clk = 1'b0;
    logic           reset, start, pause;
    logic           fb_luma4x4, fb_chromab8x8, fb_chromar8x8;
    logic [NST-1:0] enabler;
    logic           chroma_en;
    logic [31:0]    mbnumber_luma4x4, mbnumber_chromab8x8, mbnumber_chromar8x8;
    logic           busy, frame_done, error;

    int checks = 0;
    int errors = 0;

    intra_pass_scheduler #(
        .WIDTH(16), .LENGTH(8), .NSTAGE(NST), .FB_TIMEOUT(15)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause),
        .fb_luma4x4(fb_luma4x4), .fb_chromab8x8(fb_chromab8x8), .fb_chromar8x8(fb_chromar8x8),
        .enabler(enabler), .chroma_en(chroma_en),
        .mbnumber_luma4x4(mbnumber_luma4x4), .mbnumber_chromab8x8(mbnumber_chromab8x8),
        .mbnumber_chromar8x8(mbnumber_chromar8x8),
        .busy(busy), .frame_done(frame_done), .error(error)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fb(input logic l, input logic b, input logic r);
        fb_luma4x4    = l;
        fb_chromab8x8 = b;
        fb_chromar8x8 = r;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (enabler !== '0) begin errors++; $display("FAIL reset_enabler got %b want 0", enabler); end
        checks++;
        if ({chroma_en, busy, frame_done, error} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b want 0000", {chroma_en, busy, frame_done, error});
        end
        checks++;
        if ({mbnumber_luma4x4, mbnumber_chromab8x8, mbnumber_chromar8x8} !== 96'd0) begin
            errors++; $display("FAIL reset_mbnumbers got %0d/%0d/%0d want 0/0/0",
                mbnumber_luma4x4, mbnumber_chromab8x8, mbnumber_chromar8x8);
        end
    endtask

    task automatic test_full_frame();
        logic [NST-1:0] exp_en;
        set_fb(1'b1, 1'b1, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int p = 0; p < 8; p++) begin
            for (int k = 0; k < NST; k++) begin
                exp_en = NST'(1) << k;
                checks++;
                if ({enabler, busy, chroma_en} !== {exp_en, 1'b1, (p % 4 == 0)}) begin
                    errors++; $display("FAIL frame_run p%0d k%0d got en=%b busy=%b cen=%b want en=%b busy=1 cen=%b",
                        p, k, enabler, busy, chroma_en, exp_en, (p % 4 == 0));
                end
                checks++;
                if ({mbnumber_luma4x4, mbnumber_chromab8x8, mbnumber_chromar8x8} !==
                    {32'(p), 32'(p / 4), 32'(p / 4)}) begin
                    errors++; $display("FAIL frame_idx p%0d k%0d got %0d/%0d/%0d want %0d/%0d/%0d", p, k,
                        mbnumber_luma4x4, mbnumber_chromab8x8, mbnumber_chromar8x8, p, p / 4, p / 4);
                end
                tick();
            end
            checks++;
            if ({enabler, busy, frame_done} !== {NST'(0), 1'b1, 1'b0}) begin
                errors++; $display("FAIL frame_wait p%0d got en=%b busy=%b done=%b want en=0 busy=1 done=0",
                    p, enabler, busy, frame_done);
            end
            tick();
        end
        checks++;
        if ({frame_done, busy, enabler} !== {1'b1, 1'b0, NST'(0)}) begin
            errors++; $display("FAIL frame_done_pulse got done=%b busy=%b en=%b want done=1 busy=0 en=0",
                frame_done, busy, enabler);
        end
        tick();
        checks++;
        if ({frame_done, busy} !== 2'b00) begin
            errors++; $display("FAIL frame_done_width got done=%b busy=%b want 0 0", frame_done, busy);
        end
        checks++;
        if ({mbnumber_luma4x4, mbnumber_chromab8x8, mbnumber_chromar8x8} !== 96'd0) begin
            errors++; $display("FAIL frame_idle_idx got %0d/%0d/%0d want 0/0/0",
                mbnumber_luma4x4, mbnumber_chromab8x8, mbnumber_chromar8x8);
        end
        set_fb(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_late_fb();
        do_reset();
        set_fb(1'b0, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        set_fb(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < NST; k++) tick();
        set_fb(1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if ({enabler, chroma_en, mbnumber_luma4x4} !== {NST'(1), 1'b0, 32'd1}) begin
            errors++; $display("FAIL latefb_pass1 got en=%b cen=%b luma=%0d want en=1 cen=0 luma=1",
                enabler, chroma_en, mbnumber_luma4x4);
        end
        for (int k = 0; k < NST - 1; k++) tick();
        checks++;
        if (enabler !== NST'(9'h100)) begin
            errors++; $display("FAIL latefb_stage8 got %b want 100000000", enabler);
        end
        fb_luma4x4 = 1'b1;
        tick();
        fb_luma4x4 = 1'b0;
        checks++;
        if ({enabler, busy} !== {NST'(0), 1'b1}) begin
            errors++; $display("FAIL latefb_wait got en=%b busy=%b want en=0 busy=1", enabler, busy);
        end
        tick();
        checks++;
        if ({enabler, mbnumber_luma4x4} !== {NST'(1), 32'd2}) begin
            errors++; $display("FAIL latefb_advance got en=%b luma=%0d want en=1 luma=2",
                enabler, mbnumber_luma4x4);
        end
        do_reset();
    endtask

    task automatic test_timeout();
        do_reset();
        set_fb(1'b1, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < NST; k++) tick();
        for (int k = 0; k < 14; k++) tick();
        checks++;
        if ({busy, error} !== 2'b10) begin
            errors++; $display("FAIL timeout_early got busy=%b err=%b want busy=1 err=0", busy, error);
        end
        tick();
        checks++;
        if ({error, busy, enabler, mbnumber_luma4x4} !== {1'b1, 1'b0, NST'(0), 32'd0}) begin
            errors++; $display("FAIL timeout_err got err=%b busy=%b en=%b luma=%0d want err=1 busy=0 en=0 luma=0",
                error, busy, enabler, mbnumber_luma4x4);
        end
        set_fb(1'b0, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if ({error, busy, enabler} !== {1'b1, 1'b0, NST'(0)}) begin
            errors++; $display("FAIL timeout_start_ignored got err=%b busy=%b en=%b want err=1 busy=0 en=0",
                error, busy, enabler);
        end
        do_reset();
        checks++;
        if (error !== 1'b0) begin errors++; $display("FAIL timeout_reset_clears got %b want 0", error); end
    endtask

    task automatic test_pause();
        logic [NST-1:0] exp_en;
        do_reset();
        set_fb(1'b1, 1'b1, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        checks++;
        if (enabler !== NST'(9'h008)) begin errors++; $display("FAIL pause_pre got %b want 000001000", enabler); end
        pause = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({enabler, busy, mbnumber_luma4x4} !== {NST'(0), 1'b1, 32'd0}) begin
                errors++; $display("FAIL pause_hold c%0d got en=%b busy=%b luma=%0d want en=0 busy=1 luma=0",
                    k, enabler, busy, mbnumber_luma4x4);
            end
            tick();
        end
        pause = 1'b0;
        #1;
        for (int k = 3; k < NST; k++) begin
            exp_en = NST'(1) << k;
            checks++;
            if (enabler !== exp_en) begin
                errors++; $display("FAIL pause_resume k%0d got %b want %b", k, enabler, exp_en);
            end
            tick();
        end
        tick();
        checks++;
        if ({enabler, mbnumber_luma4x4} !== {NST'(1), 32'd1}) begin
            errors++; $display("FAIL pause_pass_len got en=%b luma=%0d want en=1 luma=1",
                enabler, mbnumber_luma4x4);
        end
        set_fb(1'b0, 1'b0, 1'b0);
        do_reset();
    endtask

    task automatic test_midframe_reset();
        do_reset();
        set_fb(1'b1, 1'b1, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 32; k++) tick();
        checks++;
        if ({enabler, mbnumber_luma4x4} !== {NST'(4), 32'd3}) begin
            errors++; $display("FAIL midrst_pre got en=%b luma=%0d want en=100 luma=3", enabler, mbnumber_luma4x4);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({enabler, chroma_en, busy, frame_done, error, mbnumber_luma4x4, mbnumber_chromab8x8,
             mbnumber_chromar8x8} !== '0) begin
            errors++; $display("FAIL midrst_outputs got en=%b cen=%b busy=%b luma=%0d cb=%0d want all 0",
                enabler, chroma_en, busy, mbnumber_luma4x4, mbnumber_chromab8x8);
        end
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        checks++;
        if ({busy, enabler} !== {1'b0, NST'(0)}) begin
            errors++; $display("FAIL reset_beats_start got busy=%b en=%b want 0 0", busy, enabler);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({enabler, chroma_en, mbnumber_luma4x4} !== {NST'(1), 1'b1, 32'd0}) begin
            errors++; $display("FAIL midrst_restart got en=%b cen=%b luma=%0d want en=1 cen=1 luma=0",
                enabler, chroma_en, mbnumber_luma4x4);
        end
        set_fb(1'b0, 1'b0, 1'b0);
        do_reset();
    endtask

    task automatic test_start_ignored();
        int n;
        do_reset();
        set_fb(1'b1, 1'b1, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({enabler, mbnumber_luma4x4} !== {NST'(9'h010), 32'd0}) begin
            errors++; $display("FAIL start_in_run got en=%b luma=%0d want en=000010000 luma=0",
                enabler, mbnumber_luma4x4);
        end
        n = 0;
        while (frame_done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 76) begin
            errors++; $display("FAIL start_frame_latency got %0d cycles want 76", n);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({busy, enabler, frame_done} !== {1'b0, NST'(0), 1'b0}) begin
            errors++; $display("FAIL start_in_done got busy=%b en=%b done=%b want 0 0 0", busy, enabler, frame_done);
        end
        tick();
        checks++;
        if ({busy, enabler} !== {1'b0, NST'(0)}) begin
            errors++; $display("FAIL start_in_done_idle got busy=%b en=%b want 0 0", busy, enabler);
        end
        set_fb(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        pause = 1'b0;
        set_fb(1'b0, 1'b0, 1'b0);
        test_reset();
        test_full_frame();
        test_late_fb();
        test_timeout();
        test_pause();
        test_midframe_reset();
        test_start_ignored();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
